// File: rtl/csa_shift_add_mult_8_pkg.sv
// Shared constants, state encodings and the nibble-add helper for the
// csa_shift_add_mult_8 multiplier and its csa_8_bit carry-select adder.
package csa_shift_add_mult_8_pkg;

  localparam int CSA_WIDTH  = 8;
  localparam int PROD_WIDTH = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // 4-bit add returning {carry, sum}; the building block of each select group
  function automatic logic [4:0] nibble_add(input logic [3:0] x,
                                            input logic [3:0] y,
                                            input logic       ci);
    return {1'b0, x} + {1'b0, y} + {4'b0000, ci};
  endfunction

endpackage

// File: rtl/csa_8_bit.sv
// 8-bit carry-select adder: the low nibble ripples while the high nibble is
// precomputed for both carry values and selected by the low-nibble carry.
module csa_8_bit
  import csa_shift_add_mult_8_pkg::*;
(
  input  logic [CSA_WIDTH-1:0] a,
  input  logic [CSA_WIDTH-1:0] b,
  input  logic                 c_in,
  output logic [CSA_WIDTH-1:0] sum,
  output logic                 c_out
);

  logic [4:0] low_res;
  logic [4:0] high_res0;
  logic [4:0] high_res1;

  assign low_res   = nibble_add(a[3:0], b[3:0], c_in);
  assign high_res0 = nibble_add(a[7:4], b[7:4], 1'b0);
  assign high_res1 = nibble_add(a[7:4], b[7:4], 1'b1);

  always_comb begin
    sum[3:0] = low_res[3:0];
    if (low_res[4]) begin
      sum[7:4] = high_res1[3:0];
      c_out    = high_res1[4];
    end else begin
      sum[7:4] = high_res0[3:0];
      c_out    = high_res0[4];
    end
  end

endmodule

// File: rtl/csa_shift_add_mult_8.sv
// Sequential 8x8 unsigned shift-and-add multiplier built around csa_8_bit.
// Optional macro MULT_ZERO_SKIP_EN: zero operands complete in one cycle.
module csa_shift_add_mult_8
  import csa_shift_add_mult_8_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [1:0]         state;
  logic [WIDTH-1:0]   m;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   q;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               c_out;
  logic [2*WIDTH-1:0] shifted;

  assign addend = q[0] ? m : '0;

  csa_8_bit u_adder (
    .a     (acc),
    .b     (addend),
    .c_in  (1'b0),
    .sum   (sum),
    .c_out (c_out)
  );

  // {C,A,Q} >> 1 with the adder carry landing in the MSB of A; C is always 0 after
  assign shifted = {c_out, sum, q[WIDTH-1:1]};

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      m       <= '0;
      acc     <= '0;
      q       <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            m     <= a_in;
            q     <= b_in;
            acc   <= '0;
            cnt   <= '0;
            state <= ST_RUN;
`ifdef MULT_ZERO_SKIP_EN
            if ((a_in == '0) || (b_in == '0)) begin
              state   <= ST_DONE;
              product <= '0;
            end
`endif
          end
        end
        ST_RUN: begin
          {acc, q} <= shifted;
          cnt      <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            product <= shifted;
            state   <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
